// File: rtl/keypad_pkg.sv
// Shared types, key map and row-pattern helpers for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

   localparam logic [3:0] ROWS_IDLE = 4'hF;
   localparam int         NCOLS     = 4;

   // Indexed [col][row]
   localparam logic [3:0] KEYMAP [NCOLS][4] = '{
      '{4'h1, 4'h4, 4'h7, 4'h0},
      '{4'h2, 4'h5, 4'h8, 4'hF},
      '{4'h3, 4'h6, 4'h9, 4'hE},
      '{4'hA, 4'hB, 4'hC, 4'hD}
   };

   function automatic logic single_low(input logic [3:0] rows);
      logic [3:0] act;
      act = ~rows;
      return (act != 4'h0) && ((act & (act - 4'h1)) == 4'h0);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchroniser with parameterised width and reset value.
module sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] stage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta  <= RST_VAL;
         stage <= RST_VAL;
      end else begin
         meta  <= d;
         stage <= meta;
      end
   end

   assign q = stage;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with debounce; KEYPAD_SHIFT_EN enables the
// four-key history register on the digits output.
//
// state    | meaning
// SCAN     | rotating the low column, waiting for a single-row press
// DEBOUNCE | column held, row pattern must stay identical for DB_TICKS ticks
// PRESSED  | key accepted, waiting for all rows to return high
// RELEASE  | rows idle, must stay idle for DB_TICKS ticks before rescanning
module keypad_scan #(
   parameter int SCAN_DIV = 25000,
   parameter int DB_TICKS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_n,
   output logic [3:0]  col_n,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_down,
   output logic [15:0] digits
);

   import keypad_pkg::*;

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

   logic [3:0]       row_s;
   logic [DIV_W-1:0] div;
   logic             tick;

   kp_state_t        state, state_nxt;
   logic [1:0]       col_idx, col_idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       row_pat, row_pat_nxt;
   logic [3:0]       key_code_nxt;
   logic             key_valid_nxt;
   logic             key_down_nxt;

   sync2 #(.WIDTH(4), .RST_VAL(ROWS_IDLE)) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_n),
      .q   (row_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   assign tick = (div == DIV_LAST);

   always_comb begin
      state_nxt     = state;
      col_idx_nxt   = col_idx;
      cnt_nxt       = cnt;
      row_pat_nxt   = row_pat;
      key_code_nxt  = key_code;
      key_valid_nxt = 1'b0;
      key_down_nxt  = key_down;
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (single_low(row_s)) begin
                  state_nxt   = DEBOUNCE;
                  row_pat_nxt = row_s;
                  cnt_nxt     = '0;
               end else begin
                  col_idx_nxt = col_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (row_s == row_pat) begin
                  if (cnt == CNT_LAST) begin
                     state_nxt     = PRESSED;
                     key_code_nxt  = KEYMAP[col_idx][low_index(row_pat)];
                     key_valid_nxt = 1'b1;
                     key_down_nxt  = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end else begin
                  state_nxt   = SCAN;
                  col_idx_nxt = col_idx + 2'd1;
               end
            end
            PRESSED: begin
               // Extra rows going low while a key is held are ignored.
               if (row_s == ROWS_IDLE) begin
                  state_nxt = RELEASE;
                  cnt_nxt   = '0;
               end
            end
            RELEASE: begin
               if (row_s == ROWS_IDLE) begin
                  if (cnt == CNT_LAST) begin
                     state_nxt    = SCAN;
                     key_down_nxt = 1'b0;
                     col_idx_nxt  = col_idx + 2'd1;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end else begin
                  state_nxt = PRESSED;
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         col_idx   <= 2'd0;
         cnt       <= '0;
         row_pat   <= ROWS_IDLE;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         state     <= state_nxt;
         col_idx   <= col_idx_nxt;
         cnt       <= cnt_nxt;
         row_pat   <= row_pat_nxt;
         key_code  <= key_code_nxt;
         key_valid <= key_valid_nxt;
         key_down  <= key_down_nxt;
      end
   end

   assign col_n = ~(4'b0001 << col_idx);

`ifdef KEYPAD_SHIFT_EN
   logic [15:0] digits_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digits_q <= 16'h0000;
      end else if (key_valid_nxt) begin
         digits_q <= {digits_q[11:0], key_code_nxt};
      end
   end

   assign digits = digits_q;
`else
   assign digits = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a matrix keypad model (SCAN_DIV=4, DB_TICKS=3).
module tb_keypad_scan;

   logic        clk;
   logic        rst;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [15:0] digits;

   logic [15:0] pressed;
   int          n_cmp;
   int          n_err;
   int          vld_cnt;
   logic [15:0] exp_digits;

   keypad_scan #(.SCAN_DIV(4), .DB_TICKS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .digits    (digits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key at (c,r) is bit c*4+r; it pulls row r low while column c is driven low.
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (pressed[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (key_valid === 1'b1) vld_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_digit(input logic [3:0] code);
`ifdef KEYPAD_SHIFT_EN
      exp_digits = {exp_digits[11:0], code};
`else
      exp_digits = 16'h0000;
`endif
   endtask

   task automatic press_release(input int c, input int r, input logic [3:0] code, input string tag);
      int v0;
      v0 = vld_cnt;
      pressed = '0;
      pressed[c*4+r] = 1'b1;
      cycles(100);
      push_digit(code);
      check({tag, "_valid_count"}, vld_cnt - v0, 1);
      check({tag, "_code"}, key_code, code);
      check({tag, "_digits"}, digits, exp_digits);
      pressed = '0;
      cycles(60);
      check({tag, "_released"}, key_down, 0);
   endtask

   initial begin
      logic [3:0] prev;
      int         dwell;
      int         changes;
      int         v0;
      int         waited;

      n_cmp = 0;
      n_err = 0;
      vld_cnt = 0;
      exp_digits = 16'h0000;
      pressed = '0;
      rst = 1'b1;

      cycles(3);
      check("rst_col_n", col_n, 4'b1110);
      check("rst_key_code", key_code, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_down", key_down, 0);
      check("rst_digits", digits, 0);

      // Idle scan: column rotates low bit 0->1->2->3->0 with a 4-cycle dwell.
      rst = 1'b0;
      prev = col_n;
      dwell = 0;
      changes = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         dwell++;
         if (col_n !== prev) begin
            check("idle_col_step", col_n, {prev[2:0], prev[3]});
            if (changes > 0) check("idle_col_dwell", dwell, 4);
            changes++;
            dwell = 0;
            prev = col_n;
         end
      end
      check("idle_changes", changes >= 9, 1);
      check("idle_no_valid", vld_cnt, 0);
      check("idle_key_code", key_code, 0);
      check("idle_key_down", key_down, 0);
      check("idle_digits", digits, 0);

      // Key '5' held for 200 cycles.
      v0 = vld_cnt;
      pressed[1*4+1] = 1'b1;
      cycles(200);
      push_digit(4'h5);
      check("k5_valid_count", vld_cnt - v0, 1);
      check("k5_code", key_code, 4'h5);
      check("k5_down_held", key_down, 1);
      check("k5_col_held", col_n, 4'b1101);
      pressed = '0;
      cycles(4);
      check("k5_down_during_release", key_down, 1);
      cycles(40);
      check("k5_down_after_release", key_down, 0);
      check("k5_code_kept", key_code, 4'h5);
      check("k5_single_pulse", vld_cnt - v0, 1);

      // Key '9' bouncing once per tick for 4 ticks, then stable.
      v0 = vld_cnt;
      for (int t = 0; t < 4; t++) begin
         pressed[2*4+2] = ~pressed[2*4+2];
         cycles(4);
      end
      check("k9_no_valid_in_bounce", vld_cnt - v0, 0);
      pressed = '0;
      pressed[2*4+2] = 1'b1;
      cycles(150);
      push_digit(4'h9);
      check("k9_valid_count", vld_cnt - v0, 1);
      check("k9_code", key_code, 4'h9);
      pressed = '0;
      cycles(60);
      check("k9_released", key_down, 0);

      // Rows 0 and 1 both low on column 0: invalid, scan keeps moving.
      v0 = vld_cnt;
      pressed[0] = 1'b1;
      pressed[1] = 1'b1;
      prev = col_n;
      changes = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (col_n !== prev) begin
            changes++;
            prev = col_n;
         end
      end
      check("multi_no_valid", vld_cnt - v0, 0);
      check("multi_scan_moves", changes >= 20, 1);
      check("multi_no_down", key_down, 0);
      pressed = '0;
      cycles(20);

      // Keys 1, 2, A, F in sequence; history register must read 12AF.
      press_release(0, 0, 4'h1, "k1");
      press_release(1, 0, 4'h2, "k2");
      press_release(3, 0, 4'hA, "kA");
      press_release(1, 3, 4'hF, "kF");
`ifdef KEYPAD_SHIFT_EN
      check("digits_final", digits, 16'h12AF);
`else
      check("digits_final", digits, 16'h0000);
`endif

      // Reset while 'D' is being debounced.
      waited = 0;
      while (col_n !== 4'b1110 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("kD_wait_col0", col_n, 4'b1110);
      pressed[3*4+3] = 1'b1;
      waited = 0;
      while (col_n !== 4'b0111 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("kD_wait_col3", col_n, 4'b0111);
      v0 = vld_cnt;
      cycles(6);
      check("kD_not_yet_accepted", key_down, 0);
      rst = 1'b1;
      pressed = '0;
      #1;
      check("kD_rst_col_n", col_n, 4'b1110);
      check("kD_rst_key_code", key_code, 0);
      check("kD_rst_key_valid", key_valid, 0);
      check("kD_rst_key_down", key_down, 0);
      check("kD_rst_digits", digits, 0);
      cycles(3);
      rst = 1'b0;
      cycles(40);
      check("kD_no_valid_after_rst", vld_cnt - v0, 0);
      check("kD_key_code_after_rst", key_code, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
